// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared constants and types for the feature-map BRAM reader.
//   DATA_W     : width of one feature-map word
//   ROW_WORDS  : words per BRAM row (BRAM data width = ROW_WORDS*DATA_W)
//   USED_WORDS : valid words per row, taken from the row LSBs
//   NUM_ROWS   : rows per read pass, addresses 0..NUM_ROWS-1
//   ADDR_W     : BRAM port-B address width
//   RD_LAT     : BRAM read latency from enb to valid doutb
// ---------------------------------------------------------------------------
package cnn_pkg;

  localparam int DATA_W     = 16;
  localparam int ROW_WORDS  = 70;
  localparam int USED_WORDS = 10;
  localparam int NUM_ROWS   = 11;
  localparam int ADDR_W     = 5;
  localparam int RD_LAT     = 2;

  localparam int BRAM_W  = ROW_WORDS * DATA_W;
  localparam int USED_W  = USED_WORDS * DATA_W;
  localparam int WORD_CW = $clog2(USED_WORDS);
  localparam int ROW_CW  = $clog2(NUM_ROWS);
  localparam int LAT_CW  = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    FM_IDLE  = 3'd0,
    FM_FETCH = 3'd1,
    FM_WAIT  = 3'd2,
    FM_SEND  = 3'd3,
    FM_DONE  = 3'd4
  } fm_rd_state_t;

endpackage

// File: rtl/fm_bram_reader_if.sv
// ---------------------------------------------------------------------------
// fm_bram_reader_if
// Bundles the BRAM port-B signals and the outgoing word stream.
//   master : reader side (drives enb/addrb and the word stream)
//   slave  : BRAM + downstream side (drives doutb and word_ready)
// ---------------------------------------------------------------------------
interface fm_bram_reader_if;
  import cnn_pkg::*;

  logic                fm_bram_enb;
  logic [ADDR_W-1:0]   fm_bram_addrb;
  logic [BRAM_W-1:0]   fm_bram_doutb;
  logic [DATA_W-1:0]   word_out;
  logic                word_valid;
  logic                word_ready;
  logic                word_last;

  modport master (
    output fm_bram_enb,
    output fm_bram_addrb,
    input  fm_bram_doutb,
    output word_out,
    output word_valid,
    input  word_ready,
    output word_last
  );

  modport slave (
    input  fm_bram_enb,
    input  fm_bram_addrb,
    output fm_bram_doutb,
    input  word_out,
    input  word_valid,
    output word_ready,
    input  word_last
  );

endinterface

// File: rtl/fm_row_serializer.sv
// ---------------------------------------------------------------------------
// fm_row_serializer
// Holds one unpacked row and emits its words one per valid/ready beat.
//   clk, rst    : clock, async active-high reset
//   load_i      : capture row_i and start emitting from word 0
//   row_i       : lower USED_WORDS words of the BRAM row
//   last_row_i  : the loaded row is the final row of the pass
//   ready_i     : downstream accepts the current word
//   word_o      : current word
//   valid_o     : word_o is valid
//   last_o      : current word is the final word of the final row
//   row_done_o  : final word of the row is being accepted this cycle
// ---------------------------------------------------------------------------
module fm_row_serializer
  import cnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [USED_W-1:0] row_i,
  input  logic              last_row_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] word_o,
  output logic              valid_o,
  output logic              last_o,
  output logic              row_done_o
);

  localparam logic [WORD_CW-1:0] LAST_WORD = WORD_CW'(USED_WORDS - 1);
  localparam logic [WORD_CW-1:0] PENULT    = WORD_CW'(USED_WORDS - 2);

  logic [USED_W-1:0]  buf_q, buf_d;
  logic [WORD_CW-1:0] word_q, word_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               beat_s;

  assign beat_s     = valid_q & ready_i;
  assign row_done_o = beat_s & (word_q == LAST_WORD);

  // The buffer shifts down one word per beat so the current word always sits
  // in the low bits and word_o comes straight from flops.
  // Next-state logic for buffer, word counter, valid and last flags.
  always_comb begin
    buf_d   = buf_q;
    word_d  = word_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load_i) begin
      buf_d   = row_i;
      word_d  = {WORD_CW{1'b0}};
      valid_d = 1'b1;
      last_d  = last_row_i & (LAST_WORD == {WORD_CW{1'b0}});
    end else if (beat_s) begin
      buf_d = buf_q >> DATA_W;
      if (word_q == LAST_WORD) begin
        // Row finished: hold the counter at its limit, drop valid.
        word_d  = word_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        word_d  = word_q + WORD_CW'(1);
        valid_d = 1'b1;
        last_d  = last_row_i & (word_q == PENULT);
      end
    end else begin
      buf_d   = buf_q;
      word_d  = word_q;
      valid_d = valid_q;
      last_d  = last_q;
    end
  end

  // Serializer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q   <= {USED_W{1'b0}};
      word_q  <= {WORD_CW{1'b0}};
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign word_o  = buf_q[DATA_W-1:0];
  assign valid_o = valid_q;
  assign last_o  = last_q;

endmodule

// File: rtl/fm_bram_reader.sv
// ---------------------------------------------------------------------------
// fm_bram_reader
// On a rising edge of rd_en, reads rows 0..NUM_ROWS-1 from the feature-map
// BRAM port B and streams the lower USED_WORDS words of each row downstream.
//   clk, rst  : clock, async active-high reset
//   rd_en     : level enable, a rising edge starts a pass (IDLE/DONE only)
//   rd_finish : sticky pass-complete flag, cleared by the next accepted start
//   bus       : master side of fm_bram_reader_if (BRAM port B + word stream)
// ---------------------------------------------------------------------------
module fm_bram_reader
  import cnn_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  output logic                  rd_finish,
  fm_bram_reader_if.master      bus
);

  localparam logic [ROW_CW-1:0] LAST_ROW = ROW_CW'(NUM_ROWS - 1);

  fm_rd_state_t       state_q;
  logic               rd_en_q;
  logic [ROW_CW-1:0]  row_q;
  logic [LAT_CW-1:0]  lat_q;
  logic               enb_q;
  logic [ADDR_W-1:0]  addrb_q;
  logic               finish_q;

  logic start_s;
  logic load_s;
  logic last_row_s;
  logic row_done_s;
  logic unused_upper_s;

  assign start_s    = rd_en & ~rd_en_q;
  assign last_row_s = (row_q == LAST_ROW);
  // The latency counter is about to reach zero: doutb holds the fetched row.
  assign load_s     = (state_q == FM_WAIT) & (lat_q == LAT_CW'(1));

  // Words above USED_WORDS are never streamed.
  assign unused_upper_s = ^bus.fm_bram_doutb[BRAM_W-1:USED_W];

  // Read-pass FSM: edge detection, row sequencing and BRAM port-B control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FM_IDLE;
      rd_en_q  <= 1'b0;
      row_q    <= {ROW_CW{1'b0}};
      lat_q    <= {LAT_CW{1'b0}};
      enb_q    <= 1'b0;
      addrb_q  <= {ADDR_W{1'b0}};
      finish_q <= 1'b0;
    end else begin
      rd_en_q <= rd_en;
      enb_q   <= 1'b0;
      case (state_q)
        FM_IDLE, FM_DONE: begin
          if (start_s) begin
            state_q  <= FM_FETCH;
            finish_q <= 1'b0;
            row_q    <= {ROW_CW{1'b0}};
            enb_q    <= 1'b1;
            addrb_q  <= {ADDR_W{1'b0}};
          end
        end
        FM_FETCH: begin
          state_q <= FM_WAIT;
          lat_q   <= LAT_CW'(RD_LAT);
        end
        FM_WAIT: begin
          lat_q <= lat_q - LAT_CW'(1);
          if (load_s) begin
            state_q <= FM_SEND;
          end
        end
        FM_SEND: begin
          if (row_done_s) begin
            if (last_row_s) begin
              state_q  <= FM_DONE;
              finish_q <= 1'b1;
            end else begin
              // No prefetch: the next row is requested only after this one drains.
              state_q <= FM_FETCH;
              row_q   <= row_q + ROW_CW'(1);
              enb_q   <= 1'b1;
              addrb_q <= ADDR_W'(row_q + ROW_CW'(1));
            end
          end
        end
        default: begin
          state_q <= FM_IDLE;
        end
      endcase
    end
  end

  fm_row_serializer u_ser (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_s),
    .row_i      (bus.fm_bram_doutb[USED_W-1:0]),
    .last_row_i (last_row_s),
    .ready_i    (bus.word_ready),
    .word_o     (bus.word_out),
    .valid_o    (bus.word_valid),
    .last_o     (bus.word_last),
    .row_done_o (row_done_s)
  );

  assign bus.fm_bram_enb   = enb_q;
  assign bus.fm_bram_addrb = addrb_q;
  assign rd_finish         = finish_q;

endmodule

// File: tb/tb_fm_bram_reader.sv
// ---------------------------------------------------------------------------
// tb_fm_bram_reader
// Drives fm_bram_reader with a BRAM model and a downstream ready pattern and
// compares the streamed words against a queue built from the BRAM contents.
// ---------------------------------------------------------------------------
module tb_fm_bram_reader;
  import cnn_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rd_en;
  logic rd_finish;

  fm_bram_reader_if bus ();

  fm_bram_reader dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .rd_finish (rd_finish),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // BRAM contents as words, and the packed rows the model serves.
  logic [DATA_W-1:0] words [NUM_ROWS][ROW_WORDS];
  logic [BRAM_W-1:0] mem_row [NUM_ROWS];
  logic [BRAM_W-1:0] pipe1 = '0;
  logic [BRAM_W-1:0] pipe2 = '0;

  // Two-cycle read latency BRAM port B.
  always @(posedge clk) begin
    if (bus.fm_bram_enb && int'(bus.fm_bram_addrb) < NUM_ROWS)
      pipe1 <= mem_row[bus.fm_bram_addrb[ROW_CW-1:0]];
    pipe2 <= pipe1;
  end
  assign bus.fm_bram_doutb = pipe2;

  task automatic fill(input bit rnd);
    logic [BRAM_W-1:0] row;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int k = 0; k < ROW_WORDS; k++) begin
        if (k >= USED_WORDS) words[r][k] = 16'hFFFF;
        else if (rnd)        words[r][k] = 16'($urandom_range(0, 32'hFFFE));
        else                 words[r][k] = 16'(r * 16 + k);
      end
      row = '0;
      for (int k = 0; k < ROW_WORDS; k++) row[k*DATA_W +: DATA_W] = words[r][k];
      mem_row[r] = row;
    end
  endtask

  // Expected stream and monitor state.
  logic [DATA_W-1:0] exp_q[$];
  int   ncyc = 0;
  int   last_beat_cyc = -1;
  int   beats = 0;
  int   enb_cnt = 0;
  bit   fin_next = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic [DATA_W-1:0] prev_word = '0;
  logic [DATA_W-1:0] e;

  task automatic build_exp();
    exp_q.delete();
    for (int r = 0; r < NUM_ROWS; r++)
      for (int k = 0; k < USED_WORDS; k++)
        exp_q.push_back(words[r][k]);
  endtask

  // Ready pattern: 0 = always, 1 = 1,0,0,1 repeating, 2 = random.
  int rdy_mode = 0;
  int rdy_phase = 0;
  initial begin
    bus.word_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus.word_ready = 1'b1;
        1: begin
          bus.word_ready = (rdy_phase == 0 || rdy_phase == 3);
          rdy_phase = (rdy_phase + 1) % 4;
        end
        default: bus.word_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Beat monitor, sampled on the falling edge.
  always @(negedge clk) begin
    ncyc++;
    if (!rst) begin
      if (bus.fm_bram_enb) enb_cnt++;
      if (prev_valid && !prev_ready) begin
        check_eq("stall_valid", 32'(bus.word_valid), 32'd1);
        check_eq("stall_data", 32'(bus.word_out), 32'(prev_word));
      end
      if (bus.word_valid && !prev_valid && last_beat_cyc >= 0)
        check_eq("row_gap", 32'(ncyc - last_beat_cyc), 32'd4);
      if (fin_next) begin
        check_eq("finish_rise", 32'(rd_finish), 32'd1);
        fin_next = 1'b0;
      end
      if (bus.word_valid && bus.word_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("word", 32'(bus.word_out), 32'(e));
          check_eq("no_ffff", 32'(bus.word_out == 16'hFFFF), 32'd0);
          check_eq("last", 32'(bus.word_last), 32'(exp_q.size() == 0));
          if (exp_q.size() == 0) begin
            check_eq("finish_early", 32'(rd_finish), 32'd0);
            fin_next = 1'b1;
          end
        end
        beats++;
        last_beat_cyc = ncyc;
      end
    end
    prev_valid = bus.word_valid;
    prev_ready = bus.word_ready;
    prev_word  = bus.word_out;
  end

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_enb"},    32'(bus.fm_bram_enb),   32'd0);
    check_eq({tag, "_addrb"},  32'(bus.fm_bram_addrb), 32'd0);
    check_eq({tag, "_valid"},  32'(bus.word_valid),    32'd0);
    check_eq({tag, "_word"},   32'(bus.word_out),      32'd0);
    check_eq({tag, "_last"},   32'(bus.word_last),     32'd0);
    check_eq({tag, "_finish"}, 32'(rd_finish),         32'd0);
  endtask

  // Produce a fresh rising edge of rd_en and check the start-up latency.
  task automatic start_pass();
    logic [DATA_W-1:0] first;
    @(posedge clk); #1; rd_en = 1'b0;
    @(posedge clk); #1;
    build_exp();
    first = exp_q[0];
    last_beat_cyc = -1; beats = 0; enb_cnt = 0; fin_next = 1'b0;
    rd_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("lat_enb", 32'(bus.fm_bram_enb), 32'd1);
    check_eq("lat_addr0", 32'(bus.fm_bram_addrb), 32'd0);
    check_eq("lat_finish_clr", 32'(rd_finish), 32'd0);
    @(negedge clk);
    check_eq("lat_enb_pulse", 32'(bus.fm_bram_enb), 32'd0);
    check_eq("lat_valid_early1", 32'(bus.word_valid), 32'd0);
    @(negedge clk);
    check_eq("lat_valid_early2", 32'(bus.word_valid), 32'd0);
    @(negedge clk);
    check_eq("lat_valid", 32'(bus.word_valid), 32'd1);
    check_eq("lat_first_word", 32'(bus.word_out), 32'(first));
  endtask

  task automatic wait_finish();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rd_finish) break;
    end
    check_eq("finish_seen", 32'(rd_finish), 32'd1);
  endtask

  task automatic end_checks();
    repeat (20) @(negedge clk);
    check_eq("beats", 32'(beats), 32'(NUM_ROWS * USED_WORDS));
    check_eq("enb_pulses", 32'(enb_cnt), 32'(NUM_ROWS));
    check_eq("exp_left", 32'(exp_q.size()), 32'd0);
    check_eq("finish_hold", 32'(rd_finish), 32'd1);
    check_eq("done_valid", 32'(bus.word_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1;
    rd_en = 1'b0;
    rdy_mode = 0;
    fill(1'b0);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Pass A: full ready, rd_en held high afterwards -> exactly one pass.
    start_pass();
    wait_finish();
    end_checks();

    // Pass B: new edge in DONE, 1,0,0,1 backpressure, extra edge mid-pass ignored.
    rdy_mode = 1;
    start_pass();
    repeat (30) @(posedge clk);
    #1 rd_en = 1'b0;
    @(posedge clk); #1 rd_en = 1'b1;
    wait_finish();
    end_checks();

    // Pass C: random row data and random ready.
    fill(1'b1);
    rdy_mode = 2;
    start_pass();
    wait_finish();
    end_checks();

    // Pass D: async reset in SEND of row 5, rd_en still high at release.
    fill(1'b0);
    rdy_mode = 0;
    start_pass();
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (bus.word_valid && bus.fm_bram_addrb == 5'd5) found = 1'b1;
    end
    check_eq("reach_row5", 32'(found), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_outputs_zero("async_rst");
    @(negedge clk);
    #1;
    build_exp();
    last_beat_cyc = -1; beats = 0; enb_cnt = 0; fin_next = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("restart_enb", 32'(bus.fm_bram_enb), 32'd1);
    check_eq("restart_addr0", 32'(bus.fm_bram_addrb), 32'd0);
    wait_finish();
    end_checks();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
